// File: rtl/ex_pkg.sv
// Shared definitions for the multi-cycle execute stage: FSM states, ALU and mux codes,
// and XLEN-derived widths.
package ex_pkg;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} ex_state_t;

  localparam logic [4:0] ALU_ADD   = 5'h00;
  localparam logic [4:0] ALU_SUB   = 5'h01;
  localparam logic [4:0] ALU_SLT   = 5'h02;
  localparam logic [4:0] ALU_SLTU  = 5'h03;
  localparam logic [4:0] ALU_AND   = 5'h04;
  localparam logic [4:0] ALU_OR    = 5'h05;
  localparam logic [4:0] ALU_XOR   = 5'h06;
  localparam logic [4:0] ALU_SLL   = 5'h07;
  localparam logic [4:0] ALU_SRL   = 5'h08;
  localparam logic [4:0] ALU_SRA   = 5'h09;
  localparam logic [4:0] ALU_MUL   = 5'h0a;
  localparam logic [4:0] ALU_MULHU = 5'h0b;
  localparam logic [4:0] ALU_DIV   = 5'h0c;
  localparam logic [4:0] ALU_DIVU  = 5'h0d;
  localparam logic [4:0] ALU_REM   = 5'h0e;
  localparam logic [4:0] ALU_REMU  = 5'h0f;

  localparam logic [1:0] OPA_RS1  = 2'd0;
  localparam logic [1:0] OPA_NPC  = 2'd1;
  localparam logic [1:0] OPA_PC   = 2'd2;
  localparam logic [1:0] OPA_ZERO = 2'd3;
  localparam logic [1:0] OPB_RS2  = 2'd0;
  localparam logic [1:0] OPB_IMM  = 2'd1;
  localparam logic [1:0] OPB_FOUR = 2'd2;
  localparam logic [1:0] OPB_ZERO = 2'd3;

  localparam logic [31:0] BAAD_WORD = 32'hbaadbeef;

  function automatic int shamt_w(int xlen);
    return $clog2(xlen);
  endfunction

  // one extra bit so the counter can hold XLEN itself
  function automatic int cnt_w(int xlen);
    return $clog2(xlen) + 1;
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Radix-2 iterative unit: shift-add multiply or restoring divide on unsigned operands.
// One step per cycle for XLEN cycles; done is high during the final step.
module muldiv_iter
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              abort,
  input  logic              start,
  input  logic              is_div,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic              done,
  output logic [2*XLEN-1:0] prod,
  output logic [XLEN-1:0]   quo,
  output logic [XLEN-1:0]   rem
);
  localparam int CW = cnt_w(XLEN);

  logic [CW-1:0]   cnt;
  logic [2*XLEN:0] acc, acc_nxt;
  logic [XLEN-1:0] b_q;
  logic            div_q;
  logic [XLEN:0]   sum, r_sh, diff, r_new;
  logic            q_bit;

  // acc holds {partial/remainder, multiplier/quotient}; both algorithms share it
  always_comb begin
    sum     = acc[2*XLEN:XLEN] + {1'b0, (acc[0] ? b_q : {XLEN{1'b0}})};
    r_sh    = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    diff    = r_sh - {1'b0, b_q};
    q_bit   = !diff[XLEN];
    r_new   = q_bit ? diff : r_sh;
    acc_nxt = div_q ? {r_new, acc[XLEN-2:0], q_bit}
                    : {1'b0, sum, acc[XLEN-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      acc   <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
    end else if (abort) begin
      cnt <= '0;
    end else if (start) begin
      cnt   <= CW'(XLEN);
      acc   <= {{(XLEN+1){1'b0}}, a};
      b_q   <= b;
      div_q <= is_div;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
      acc <= acc_nxt;
    end
  end

  assign done = (cnt == CW'(1));
  assign prod = acc_nxt[2*XLEN-1:0];
  assign quo  = acc[XLEN-1:0];
  assign rem  = acc[2*XLEN-1:XLEN];

endmodule

// File: rtl/ex_stage_mc.sv
// Multi-cycle execute stage: operand muxes, ALU, branch resolve and mul/div sequencing
// behind a valid/ready handshake on both sides.
//   state | meaning
//   IDLE  | accepting ops; single-cycle results written straight to the output register
//   MUL   | multiplier iterating
//   DIV   | divider iterating on operand magnitudes
//   FIX   | applying quotient/remainder sign, then result
module ex_stage_mc
  import ex_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit EN_MULDIV = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_rega,
  input  logic [XLEN-1:0] in_regb,
  input  logic [XLEN-1:0] in_pc_add_opa,
  input  logic [1:0]      in_opa_select,
  input  logic [1:0]      in_opb_select,
  input  logic [4:0]      in_alu_func,
  input  logic [2:0]      in_funct3,
  input  logic            in_uncond_branch,
  input  logic            in_cond_branch,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_take_branch,
  output logic [XLEN-1:0] out_target_pc
);
  localparam int SHW = shamt_w(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  ex_state_t         state, state_nxt;
  logic [XLEN-1:0]   opa, opb, alu_res, a_mag, b_mag, baad, fix_res, mul_res;
  logic [SHW-1:0]    shamt;
  logic              brcond, fire, md_code, is_mul, is_div, div_signed;
  logic              b_zero, div_ovf, div_fast, a_neg, b_neg, it_start, it_done;
  logic [2*XLEN-1:0] it_prod;
  logic [XLEN-1:0]   it_quo, it_rem;
  logic [4:0]        func_q;
  logic              neg_q, neg_r;

  for (genvar g = 0; g < XLEN; g++) begin : g_baad
    assign baad[g] = BAAD_WORD[g % 32];
  end

  assign in_ready = (state == IDLE) && (!out_valid || out_ready) && !flush;
  assign fire     = in_valid && in_ready;

  always_comb begin
    case (in_opa_select)
      OPA_RS1: opa = in_rega;
      OPA_NPC: opa = in_pc + XLEN'(4);
      OPA_PC:  opa = in_pc;
      default: opa = '0;
    endcase
    case (in_opb_select)
      OPB_RS2:  opb = in_regb;
      OPB_IMM:  opb = in_imm;
      OPB_FOUR: opb = XLEN'(4);
      default:  opb = '0;
    endcase
  end

  always_comb begin
    case (in_funct3)
      3'b000:  brcond = (in_rega == in_regb);
      3'b001:  brcond = (in_rega != in_regb);
      3'b100:  brcond = ($signed(in_rega) < $signed(in_regb));
      3'b101:  brcond = ($signed(in_rega) >= $signed(in_regb));
      3'b110:  brcond = (in_rega < in_regb);
      3'b111:  brcond = (in_rega >= in_regb);
      default: brcond = 1'b0;
    endcase
  end

  assign md_code    = in_alu_func inside {ALU_MUL, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  assign is_mul     = EN_MULDIV && (in_alu_func inside {ALU_MUL, ALU_MULHU});
  assign is_div     = EN_MULDIV && (in_alu_func inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU});
  assign div_signed = (in_alu_func == ALU_DIV) || (in_alu_func == ALU_REM);
  assign b_zero     = (opb == '0);
  assign div_ovf    = div_signed && (opa == MIN_NEG) && (opb == '1);
  assign div_fast   = is_div && (b_zero || div_ovf);
  assign a_neg      = div_signed && opa[XLEN-1];
  assign b_neg      = div_signed && opb[XLEN-1];
  assign a_mag      = a_neg ? -opa : opa;
  assign b_mag      = b_neg ? -opb : opb;
  assign it_start   = fire && (is_mul || (is_div && !div_fast));
  assign shamt      = opb[SHW-1:0];

  always_comb begin
    alu_res = baad;
    case (in_alu_func)
      ALU_ADD:  alu_res = opa + opb;
      ALU_SUB:  alu_res = opa - opb;
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(opa) < $signed(opb)};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, opa < opb};
      ALU_AND:  alu_res = opa & opb;
      ALU_OR:   alu_res = opa | opb;
      ALU_XOR:  alu_res = opa ^ opb;
      ALU_SLL:  alu_res = opa << shamt;
      ALU_SRL:  alu_res = opa >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(opa) >>> shamt);
      ALU_DIV, ALU_DIVU: if (div_fast) alu_res = b_zero ? '1 : opa;
      ALU_REM, ALU_REMU: if (div_fast) alu_res = b_zero ? opa : '0;
      default:  alu_res = baad;
    endcase
  end

  muldiv_iter #(.XLEN(XLEN)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .abort  (flush),
    .start  (it_start),
    .is_div (is_div),
    .a      (is_div ? a_mag : opa),
    .b      (is_div ? b_mag : opb),
    .done   (it_done),
    .prod   (it_prod),
    .quo    (it_quo),
    .rem    (it_rem)
  );

  assign mul_res = (func_q == ALU_MULHU) ? it_prod[2*XLEN-1:XLEN] : it_prod[XLEN-1:0];
  assign fix_res = (func_q inside {ALU_REM, ALU_REMU}) ? (neg_r ? -it_rem : it_rem)
                                                       : (neg_q ? -it_quo : it_quo);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (it_start) state_nxt = is_mul ? MUL : DIV;
      MUL:     if (it_done) state_nxt = IDLE;
      DIV:     if (it_done) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // branch info is latched at accept; out_valid is low until a multi-cycle result lands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid       <= 1'b0;
      out_result      <= '0;
      out_take_branch <= 1'b0;
      out_target_pc   <= '0;
      func_q          <= ALU_ADD;
      neg_q           <= 1'b0;
      neg_r           <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (fire) begin
      out_target_pc   <= in_pc_add_opa + in_imm;
      out_take_branch <= !md_code && (in_uncond_branch || (in_cond_branch && brcond));
      func_q          <= in_alu_func;
      neg_q           <= a_neg ^ b_neg;
      neg_r           <= a_neg;
      out_valid       <= !it_start;
      if (!it_start) out_result <= alu_res;
    end else if (state == MUL && it_done) begin
      out_result <= mul_res;
      out_valid  <= 1'b1;
    end else if (state == FIX) begin
      out_result <= fix_res;
      out_valid  <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
